// File: rtl/fetch_prefetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Sequential instruction fetch with a prefetch queue between the instruction
// memory port and decode. At most one memory request is outstanding; a request
// is only issued when the queue has a free slot, so a response always finds
// room. A redirect flushes the queue, loads a new PC and, if a response is
// still owed by memory, parks in DROP until that stale response is discarded.
//
// Parameters
//   ADDR_WIDTH  width of PC / memory address
//   INST_WIDTH  instruction width
//   FIFO_DEPTH  queue entries (power of two, >= 2)
//   PC_RESET    PC after reset
//   PC_INC      PC increment per fetched instruction
//   PC_WRAP     incremented PC >= PC_WRAP wraps to 0
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   Addr, req_valid fetch address and request-outstanding flag
//   we              memory write enable, tied to 0
//   Data, data_valid memory response
//   system_stall    freezes issue and dequeue (outstanding response still taken)
//   redirect_valid, redirect_pc  flush and PC reload
//   opcode, uop_valid_out, uop_ready  head of queue to decode (valid/ready)
//   uop_pc          head fetch PC, only with FETCH_PC_TAG_EN defined
//
// Build option: `define FETCH_PC_TAG_EN to store the fetch PC with each entry
// and expose it on uop_pc.
// ----------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            INST_WIDTH = 32,
    parameter int unsigned            FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0]  PC_RESET   = '0,
    parameter logic [ADDR_WIDTH-1:0]  PC_INC     = ADDR_WIDTH'(1),
    parameter logic [ADDR_WIDTH-1:0]  PC_WRAP    = ADDR_WIDTH'(256)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] Addr,
    input  logic [INST_WIDTH-1:0] Data,
    output logic                  we,
    output logic                  req_valid,
    input  logic                  data_valid,
    input  logic                  system_stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [INST_WIDTH-1:0] opcode,
`ifdef FETCH_PC_TAG_EN
    output logic [ADDR_WIDTH-1:0] uop_pc,
`endif
    output logic                  uop_valid_out,
    input  logic                  uop_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // state | meaning
    // IDLE  | no request outstanding; issue when not stalled and a slot is free
    // REQ   | request outstanding, response will be pushed
    // DROP  | request outstanding after a flush, response will be discarded
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [INST_WIDTH-1:0] inst_q [FIFO_DEPTH];
`ifdef FETCH_PC_TAG_EN
    logic [ADDR_WIDTH-1:0] tag_q  [FIFO_DEPTH];
`endif

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [CNT_W-1:0]      count_after;
    logic                  pop_ok;
    logic                  push;
    logic                  pop;
    logic                  flush;

    assign pc_inc  = pc_q + PC_INC;
    assign pc_next = (pc_inc >= PC_WRAP) ? '0 : pc_inc;

    assign uop_valid_out = (count_q != '0);
    assign pop_ok        = uop_valid_out && uop_ready && !system_stall;
    // Occupancy after this cycle's push, with a same-cycle pop taken into account.
    assign count_after   = count_q + CNT_W'(1) - CNT_W'(pop_ok);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;

        if (redirect_valid) begin
            // Redirect wins over push, pop and issue. A response still owed by
            // memory must be swallowed, hence DROP when it has not arrived yet.
            flush = 1'b1;
            pc_d  = redirect_pc;
            case (state_q)
                ST_REQ:  state_d = data_valid ? ST_IDLE : ST_DROP;
                ST_DROP: state_d = data_valid ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            pop = pop_ok;
            case (state_q)
                ST_IDLE: begin
                    if (!system_stall && (count_q < DEPTH_C)) begin
                        state_d = ST_REQ;
                        addr_d  = pc_q;
                    end
                end
                ST_REQ: begin
                    if (data_valid) begin
                        push = 1'b1;
                        pc_d = pc_next;
                        if (!system_stall && (count_after < DEPTH_C)) begin
                            addr_d = pc_next;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (data_valid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= PC_RESET;
            addr_q   <= PC_RESET;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            inst_q[wr_ptr_q] <= Data;
`ifdef FETCH_PC_TAG_EN
            tag_q[wr_ptr_q]  <= pc_q;
`endif
        end
    end

    assign Addr      = addr_q;
    assign we        = 1'b0;
    assign req_valid = (state_q != ST_IDLE);
    assign opcode    = uop_valid_out ? inst_q[rd_ptr_q] : '0;
`ifdef FETCH_PC_TAG_EN
    assign uop_pc    = uop_valid_out ? tag_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] Data;
    logic        we;
    logic        req_valid;
    logic        data_valid;
    logic        system_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] opcode;
    logic        uop_valid_out;
    logic        uop_ready;

    // memory model control
    bit          mem_auto;
    int          budget;
    logic        man_dv;
    logic [31:0] man_data;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_op[$];

    int n_checks;
    int n_err;

    fetch_prefetch_unit #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .FIFO_DEPTH (4),
        .PC_RESET   (32'd0),
        .PC_INC     (32'd1),
        .PC_WRAP    (32'd8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Addr           (Addr),
        .Data           (Data),
        .we             (we),
        .req_valid      (req_valid),
        .data_valid     (data_valid),
        .system_stall   (system_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .opcode         (opcode),
        .uop_valid_out  (uop_valid_out),
        .uop_ready      (uop_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory responder plus request and uop monitors, all sampled 1ns after
    // the falling edge so stimulus written on the falling edge is visible.
    initial begin : monitor
        logic        prev_req;
        logic        prev_dv;
        logic        is_new;
        logic [31:0] e;
        prev_req   = 1'b0;
        prev_dv    = 1'b0;
        data_valid = 1'b0;
        Data       = '0;
        forever begin
            @(negedge clk);
            #1;
            is_new = req_valid && (!prev_req || prev_dv);
            if (is_new) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_request_addr", Addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_addr.pop_front();
                    chk("request_addr", Addr, e);
                end
            end
            if (mem_auto) begin
                if (is_new && budget > 0) begin
                    data_valid = 1'b1;
                    Data       = 32'hC0DE_0000 | Addr;
                    budget     = budget - 1;
                end else begin
                    data_valid = 1'b0;
                end
            end else begin
                data_valid = man_dv;
                Data       = man_data;
            end
            if (uop_valid_out && uop_ready && !system_stall) begin
                if (exp_op.size() == 0) begin
                    chk("unexpected_uop_opcode", opcode, 32'hFFFF_FFFF);
                end else begin
                    e = exp_op.pop_front();
                    chk("uop_opcode", opcode, e);
                end
            end else if (!uop_valid_out) begin
                chk("opcode_zero_when_empty", opcode, 32'h0);
            end
            prev_req = req_valid;
            prev_dv  = data_valid;
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        mem_auto       = 1'b0;
        budget         = 0;
        man_dv         = 1'b0;
        man_data       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        system_stall   = 1'b0;
        uop_ready      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic end_check(input string nm);
        chk({nm, "_addr_queue_drained"}, 32'(exp_addr.size()), 32'd0);
        chk({nm, "_uop_queue_drained"},  32'(exp_op.size()),   32'd0);
        exp_addr.delete();
        exp_op.delete();
    endtask

    // Addresses 0..7,0,1,2 (wrap at 8); the 11th request is left unanswered.
    task automatic push_stream();
        for (int i = 0; i < 11; i++) exp_addr.push_back(32'(i % 8));
        for (int i = 0; i < 10; i++) exp_op.push_back(32'hC0DE_0000 + 32'(i % 8));
    endtask

    initial begin : stimulus
        n_checks       = 0;
        n_err          = 0;
        reset          = 1'b1;
        mem_auto       = 1'b0;
        budget         = 0;
        man_dv         = 1'b0;
        man_data       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        system_stall   = 1'b0;
        uop_ready      = 1'b0;

        // reset values
        do_reset();
        chk("reset_req_valid", 32'(req_valid),     32'd0);
        chk("reset_uop_valid", 32'(uop_valid_out), 32'd0);
        chk("reset_opcode",    opcode,             32'd0);
        chk("reset_addr",      Addr,               32'd0);
        chk("reset_we",        32'(we),            32'd0);

        // streaming, same-cycle memory, decode always ready, wrap at 8
        uop_ready = 1'b1;
        mem_auto  = 1'b1;
        budget    = 10;
        push_stream();
        repeat (12) @(negedge clk);
        chk("stream_one_per_cycle_ops",  32'(exp_op.size()),   32'd0);
        chk("stream_one_per_cycle_reqs", 32'(exp_addr.size()), 32'd0);
        chk("stream_hang_req_valid",     32'(req_valid),       32'd1);
        chk("stream_hang_addr",          Addr,                 32'd2);
        end_check("stream");

        // decode blocked: exactly FIFO_DEPTH requests, then resume at 4
        do_reset();
        mem_auto = 1'b1;
        budget   = 10;
        push_stream();
        repeat (8) @(negedge clk);
        chk("full_req_valid_low",  32'(req_valid),       32'd0);
        chk("full_four_requests",  32'(exp_addr.size()), 32'd7);
        chk("full_uop_valid",      32'(uop_valid_out),   32'd1);
        chk("full_head_opcode",    opcode,               32'hC0DE_0000);
        uop_ready = 1'b1;
        repeat (12) @(negedge clk);
        end_check("full_resume");

        // redirect with a request pending, stale 0xDEAD discarded
        do_reset();
        system_stall   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd5;
        exp_addr.push_back(32'd5);
        exp_addr.push_back(32'h40);
        @(negedge clk);
        chk("redir_idle_stays_idle", 32'(req_valid), 32'd0);
        redirect_valid = 1'b0;
        system_stall   = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        chk("drop_req_valid", 32'(req_valid), 32'd1);
        chk("drop_addr_held", Addr,           32'd5);
        chk("drop_queue_empty", 32'(uop_valid_out), 32'd0);
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        man_dv   = 1'b1;
        man_data = 32'h0000_DEAD;
        @(negedge clk);
        man_dv = 1'b0;
        chk("drop_done_req_valid", 32'(req_valid),     32'd0);
        chk("drop_not_pushed",     32'(uop_valid_out), 32'd0);
        @(negedge clk);
        chk("redir_new_req_valid", 32'(req_valid), 32'd1);
        man_dv    = 1'b1;
        man_data  = 32'h0000_1234;
        uop_ready = 1'b1;
        exp_op.push_back(32'h0000_1234);
        exp_addr.push_back(32'd0);  // 0x41 >= wrap
        @(negedge clk);
        man_dv = 1'b0;
        repeat (2) @(negedge clk);
        end_check("redirect");

        // stall with request outstanding, then flush of a non-empty queue
        do_reset();
        uop_ready = 1'b1;
        exp_addr.push_back(32'd0);
        exp_addr.push_back(32'd1);
        exp_addr.push_back(32'd2);
        exp_addr.push_back(32'd3);
        @(negedge clk);
        system_stall = 1'b1;
        @(negedge clk);
        man_dv   = 1'b1;
        man_data = 32'hAAAA_0000;
        exp_op.push_back(32'hAAAA_0000);
        @(negedge clk);
        man_dv = 1'b0;
        chk("stall_no_reissue",   32'(req_valid),     32'd0);
        chk("stall_pushed",       32'(uop_valid_out), 32'd1);
        chk("stall_head_opcode",  opcode,             32'hAAAA_0000);
        repeat (3) @(negedge clk);
        chk("stall_held_no_req",  32'(req_valid),     32'd0);
        chk("stall_held_no_pop",  32'(uop_valid_out), 32'd1);
        system_stall = 1'b0;
        @(negedge clk);
        man_dv    = 1'b1;
        man_data  = 32'hB1B1_0001;
        uop_ready = 1'b0;
        @(negedge clk);
        chk("flush_pre_valid",  32'(uop_valid_out), 32'd1);
        chk("flush_pre_opcode", opcode,             32'hB1B1_0001);
        man_dv         = 1'b1;
        man_data       = 32'hBAD2_BAD2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd3;
        @(negedge clk);
        chk("flush_uop_valid", 32'(uop_valid_out), 32'd0);
        chk("flush_opcode",    opcode,             32'd0);
        chk("flush_req_valid", 32'(req_valid),     32'd0);
        man_dv         = 1'b0;
        redirect_valid = 1'b0;
        uop_ready      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        end_check("stall_flush");

        // reset in the middle of a request, stale response ignored
        do_reset();
        exp_addr.push_back(32'd0);
        exp_addr.push_back(32'd1);
        exp_addr.push_back(32'd0);
        @(negedge clk);
        man_dv   = 1'b1;
        man_data = 32'h0000_0011;
        @(negedge clk);
        man_dv = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        chk("midreset_req_valid", 32'(req_valid),     32'd0);
        chk("midreset_uop_valid", 32'(uop_valid_out), 32'd0);
        chk("midreset_addr",      Addr,               32'd0);
        reset    = 1'b0;
        man_dv   = 1'b1;
        man_data = 32'h0000_5555;
        @(negedge clk);
        man_dv = 1'b0;
        chk("stale_not_pushed", 32'(uop_valid_out), 32'd0);
        chk("reissue_pc_reset", Addr,               32'd0);
        @(negedge clk);
        chk("stale_still_empty", 32'(uop_valid_out), 32'd0);
        @(negedge clk);
        end_check("midreset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
